// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one pipelined Wishbone bus among N_MASTERS masters.
// A grant is held for the whole cyc of a master; one idle GAP cycle separates consecutive grants.
module wb_rr_arbiter #(
   parameter int N_MASTERS       = 2,
   parameter int BYTES           = 1,
   parameter int ADDR_BITS       = 8,
   parameter int SEL_WIDTH       = 1,
   parameter int MAX_OUTSTANDING = 255
) (
   input  logic                           clk,
   input  logic                           sreset,
   input  logic [N_MASTERS*ADDR_BITS-1:0] s_wb_addr,
   input  logic [N_MASTERS*BYTES*8-1:0]   s_wb_dat_m2s,
   output logic [BYTES*8-1:0]             s_wb_dat_s2m,
   input  logic [N_MASTERS-1:0]           s_wb_we,
   input  logic [N_MASTERS*SEL_WIDTH-1:0] s_wb_sel,
   input  logic [N_MASTERS-1:0]           s_wb_stb,
   input  logic [N_MASTERS-1:0]           s_wb_cyc,
   output logic [N_MASTERS-1:0]           s_wb_ack,
   output logic [N_MASTERS-1:0]           s_wb_stall,
   output logic [ADDR_BITS-1:0]           m_wb_addr,
   output logic [BYTES*8-1:0]             m_wb_dat_m2s,
   input  logic [BYTES*8-1:0]             m_wb_dat_s2m,
   output logic                           m_wb_we,
   output logic [SEL_WIDTH-1:0]           m_wb_sel,
   output logic                           m_wb_stb,
   output logic                           m_wb_cyc,
   input  logic                           m_wb_ack,
   input  logic                           m_wb_stall,
   output logic [N_MASTERS-1:0]           grant,
   output logic                           abort_pulse,
   output logic                           stray_ack
);
   localparam int IW = $clog2(N_MASTERS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int DW = BYTES * 8;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] last_grant, pick;
   logic [CW-1:0] outstanding;
   logic any_req, in_grant, g_cyc, beat;
   assign any_req = |s_wb_cyc;
   assign in_grant = state == GRANT;
   assign g_cyc = s_wb_cyc[last_grant];
   assign beat = m_wb_stb && !m_wb_stall;
   assign s_wb_dat_s2m = m_wb_dat_s2m;
   // Descending scan: the requester nearest after last_grant is assigned last and wins.
   always_comb begin
      pick = last_grant;
      for (int k = N_MASTERS; k >= 1; k--)
         if (s_wb_cyc[(int'(last_grant) + k) % N_MASTERS])
            pick = IW'((int'(last_grant) + k) % N_MASTERS);
   end
   always_comb begin
      state_nxt = state == IDLE  ? (any_req ? GRANT : IDLE) :
                  state == GRANT ? (g_cyc ? GRANT : GAP) : IDLE;
   end
   always_comb begin
      m_wb_addr    = s_wb_addr[int'(last_grant)*ADDR_BITS +: ADDR_BITS];
      m_wb_dat_m2s = s_wb_dat_m2s[int'(last_grant)*DW +: DW];
      m_wb_sel     = s_wb_sel[int'(last_grant)*SEL_WIDTH +: SEL_WIDTH];
      m_wb_we      = s_wb_we[last_grant];
      m_wb_cyc     = in_grant && g_cyc;
      m_wb_stb     = in_grant && s_wb_stb[last_grant];
      s_wb_stall   = '1;
      s_wb_ack     = '0;
      if (in_grant) begin
         s_wb_stall[last_grant] = m_wb_stall;
         s_wb_ack[last_grant]   = m_wb_ack;
      end
   end
   always_ff @(posedge clk) begin
      if (sreset) begin
         state       <= IDLE;
         last_grant  <= IW'(N_MASTERS - 1);
         grant       <= '0;
         outstanding <= '0;
         abort_pulse <= 1'b0;
         stray_ack   <= 1'b0;
      end else begin
         state       <= state_nxt;
         abort_pulse <= in_grant && !g_cyc && outstanding != '0;
         stray_ack   <= !in_grant && m_wb_ack;
         if (state == IDLE && any_req) begin
            last_grant <= pick;
            grant      <= N_MASTERS'(1) << pick;
         end
         if (in_grant && !g_cyc)
            grant <= '0;
         outstanding <= (!in_grant || !g_cyc) ? '0 :
                        (beat && !m_wb_ack && outstanding != CW'(MAX_OUTSTANDING)) ? outstanding + 1'b1 :
                        (m_wb_ack && !beat && outstanding != '0) ? outstanding - 1'b1 : outstanding;
      end
   end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: randomized masters/slave checked every cycle against an integer-level
// arbitration model, plus directed reset-mid-burst and counter-saturation sequences.
module tb_wb_rr_arbiter;
   localparam int N = 3;
   localparam int MAXO = 7;
   logic clk, sreset;
   logic [N*8-1:0] addr, dat;
   logic [N-1:0] we, sel, stb, cyc;
   logic [7:0] s_dat_s2m, m_wb_addr, m_wb_dat_m2s, m_dat;
   logic [N-1:0] s_wb_ack, s_wb_stall, grant;
   logic m_wb_we, m_wb_stb, m_wb_cyc, abort_pulse, stray_ack, m_ack, m_stall;
   logic [0:0] m_wb_sel;
   int n_tests = 0, n_fail = 0;
   int owner, last_g, outst, pend;
   bit gap, e_abort, e_stray, manual, hot;
   int left[N];
   logic [N-1:0] e_sstall;
   logic e_mstb;

   wb_rr_arbiter #(.N_MASTERS(N), .BYTES(1), .ADDR_BITS(8), .SEL_WIDTH(1), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .sreset(sreset),
      .s_wb_addr(addr), .s_wb_dat_m2s(dat), .s_wb_dat_s2m(s_dat_s2m),
      .s_wb_we(we), .s_wb_sel(sel), .s_wb_stb(stb), .s_wb_cyc(cyc),
      .s_wb_ack(s_wb_ack), .s_wb_stall(s_wb_stall),
      .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_dat_s2m(m_dat),
      .m_wb_we(m_wb_we), .m_wb_sel(m_wb_sel), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc),
      .m_wb_ack(m_ack), .m_wb_stall(m_stall),
      .grant(grant), .abort_pulse(abort_pulse), .stray_ack(stray_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare();
      logic [N-1:0] e_grant, e_sack;
      logic e_mcyc;
      e_grant = '0;
      e_sack = '0;
      e_sstall = '1;
      e_mcyc = 1'b0;
      e_mstb = 1'b0;
      if (owner >= 0) begin
         e_grant[owner] = 1'b1;
         e_mcyc = cyc[owner];
         e_mstb = stb[owner];
         e_sack[owner] = m_ack;
         e_sstall[owner] = m_stall;
      end
      check("grant", 64'(grant), 64'(e_grant));
      check("m_cyc", 64'(m_wb_cyc), 64'(e_mcyc));
      check("m_stb", 64'(m_wb_stb), 64'(e_mstb));
      check("s_ack", 64'(s_wb_ack), 64'(e_sack));
      check("s_stall", 64'(s_wb_stall), 64'(e_sstall));
      check("abort", 64'(abort_pulse), 64'(e_abort));
      check("stray", 64'(stray_ack), 64'(e_stray));
      check("s_dat", 64'(s_dat_s2m), 64'(m_dat));
      if (e_mcyc) begin
         check("m_addr", 64'(m_wb_addr), 64'(addr[owner*8 +: 8]));
         check("m_dat", 64'(m_wb_dat_m2s), 64'(dat[owner*8 +: 8]));
         check("m_we", 64'(m_wb_we), 64'(we[owner]));
         check("m_sel", 64'(m_wb_sel), 64'(sel[owner]));
      end
   endtask

   task automatic model_reset();
      owner = -1;
      gap = 1'b0;
      last_g = N - 1;
      outst = 0;
      e_abort = 1'b0;
      e_stray = 1'b0;
   endtask

   // Next-cycle behaviour from the arbitration rules, using the inputs held this cycle.
   task automatic model_step();
      bit was_grant, b;
      was_grant = owner >= 0;
      if (sreset) model_reset();
      else begin
         e_stray = !was_grant && m_ack;
         e_abort = 1'b0;
         if (was_grant) begin
            if (!cyc[owner]) begin
               e_abort = outst != 0;
               owner = -1;
               gap = 1'b1;
               outst = 0;
            end else begin
               b = stb[owner] && !m_stall;
               if (b && !m_ack) outst = (outst == MAXO) ? MAXO : outst + 1;
               else if (m_ack && !b) outst = (outst == 0) ? 0 : outst - 1;
            end
         end else if (gap) gap = 1'b0;
         else begin
            for (int k = 1; k <= N; k++) begin
               int j;
               j = (last_g + k) % N;
               if (cyc[j]) begin
                  owner = j;
                  last_g = j;
                  break;
               end
            end
         end
      end
   endtask

   task automatic drive();
      if (!manual) begin
         sreset = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!cyc[i]) begin
               if (hot || $urandom_range(0, 3) == 0) begin
                  cyc[i] = 1'b1;
                  left[i] = hot ? 1 : int'($urandom_range(1, 5));
               end
            end else if (left[i] == 0 ? (hot || $urandom_range(0, 2) == 0) : $urandom_range(0, 24) == 0) begin
               cyc[i] = 1'b0;
               left[i] = 0;
            end
            stb[i] = cyc[i] && left[i] > 0 && (hot || $urandom_range(0, 3) != 0);
         end
         addr = 24'($urandom);
         dat = 24'($urandom);
         we = 3'($urandom);
         sel = 3'($urandom);
         m_stall = $urandom_range(0, 2) == 0;
         m_ack = pend > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0;
         m_dat = 8'($urandom);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      for (int i = 0; i < N; i++)
         if (stb[i] && !e_sstall[i] && left[i] > 0) left[i]--;
      if (e_mstb && !m_stall) pend++;
      if (m_ack && pend > 0) pend--;
      model_step();
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      sreset = 1'b1;
      {addr, dat, we, sel, stb, cyc} = '0;
      {m_ack, m_stall, m_dat} = '0;
      pend = 0;
      manual = 1'b0;
      hot = 1'b0;
      for (int i = 0; i < N; i++) left[i] = 0;
      @(posedge clk);
      #1;
      model_reset();
      repeat (1500) cycle();
      hot = 1'b1;
      repeat (400) cycle();
      hot = 1'b0;
      // Reset while master 1 owns the bus, then both 0 and 1 request.
      for (int t = 0; t < 2000 && owner != 1; t++) cycle();
      check("found_m1_owner", 64'(owner == 1), 64'(1));
      manual = 1'b1;
      sreset = 1'b1;
      cycle();
      sreset = 1'b0;
      cyc = 3'b011;
      stb = '0;
      m_ack = 1'b0;
      repeat (4) cycle();
      // Saturate the outstanding counter at MAXO, then ack down to 1 or 0 before dropping cyc.
      cyc = '0;
      m_stall = 1'b0;
      repeat (6) cycle();
      for (int nacks = 6; nacks <= 7; nacks++) begin
         cyc = 3'b001;
         cycle();
         stb = 3'b001;
         repeat (9) cycle();
         stb = '0;
         m_ack = 1'b1;
         repeat (nacks) cycle();
         m_ack = 1'b0;
         cyc = '0;
         repeat (4) cycle();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
